logic_op_arbiter: RTL
=====================

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request per requester; req[i] belongs to requester i.
REQ-005 Port: op  input  12  opcode per requester; requester i at op[3*i+2:3*i].
REQ-006 Port: a  input  4*WIDTH  operand A per requester; requester i at a[WIDTH*i+WIDTH-1:WIDTH*i].
REQ-007 Port: b  input  4*WIDTH  operand B per requester, same packing as a.
REQ-008 Port: gnt  output  4  one-hot grant pulse.
REQ-009 Port: busy  output  1  high while an operation is in flight (states GRANT, EXEC).
REQ-010 Port: res  output  WIDTH  registered result.
REQ-011 Port: res_valid  output  1  one-cycle result strobe.
REQ-012 Port: res_id  output  2  requester index owning res.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, EXEC, DONE.
- IDLE -> GRANT when any req bit is high at the clock edge; else stay.
- GRANT -> EXEC unconditionally; EXEC -> DONE unconditionally; DONE -> IDLE unconditionally.
REQ-014 IDLE->GRANT edge SHALL select a winner round-robin: search starts at last_id+1, wraps 3->0, picks the first high req bit.
REQ-015 The same edge SHALL latch the winner's op, a and b into internal registers and set last_id to the winner.
REQ-016 gnt SHALL be high for exactly the GRANT cycle, with only the winner's bit set; gnt is 0 in all other states.
REQ-017 Requesters SHALL hold req and their op/a/b stable until they see gnt; a req dropped before the edge it is sampled on is not served.
REQ-018 A requester SHALL deassert req in the cycle after gnt, or it re-enters arbitration at the next IDLE.
REQ-019 On the GRANT->EXEC edge, the latched operands SHALL feed a bitwise function into res:
- 000 AND; 001 OR; 010 NOR; 011 NAND; 100 XOR; 101 XNOR.
- 110 and 111 per REQ-028/029.
REQ-020 res_valid SHALL be high for exactly the DONE cycle, with res_id equal to the winner.
REQ-021 res and res_id SHALL hold their values until the next EXEC->DONE edge.
REQ-022 Latency: req sampled at edge k gives gnt in cycle k+1 and res_valid in cycle k+3. An operation occupies 4 cycles including IDLE, so one requester can be served at most once per 4 cycles.
REQ-023 With all four req held high, grants SHALL rotate 0,1,2,3,0,... with no requester skipped.
REQ-024 Requests arriving in GRANT, EXEC or DONE SHALL be ignored until IDLE; no queueing.

Reset
REQ-025 rst_n low SHALL asynchronously force:
- state IDLE, last_id 3 (requester 0 has first priority);
- gnt 0, busy 0, res 0, res_valid 0, res_id 0;
- latched op/a/b all 0.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight operation; no res_valid is produced for it.
REQ-027 After rst_n deasserts, the first clock edge SHALL behave as IDLE arbitration.

Configuration
REQ-028 Macro LOGIC_OP_ARBITER_ERR_EN defined: output port err (1 bit) exists. Opcodes 110/111 yield res 0, and err is high in the DONE cycle together with res_valid. err is 0 otherwise and 0 under reset.
REQ-029 Macro not defined: no err port. Opcodes 110/111 yield res 0 and complete normally with res_valid.

Verification
REQ-030 Scenario, single request: reset; req=0001, op0=010, a0=8'h0F, b0=8'hF0 -> gnt=0001 one cycle later; res_valid 2 cycles after gnt; res=8'h00, res_id=0.
REQ-031 Scenario, round-robin: all four req held high, op=001, a=8'h01<<i, b=0 -> grant order 0,1,2,3,0; res sequence 01,02,04,08,01; res_valid once every 4 cycles.
REQ-032 Scenario, opcode sweep: requester 2, a=8'hA5, b=8'h3C, ops 000..101 -> res 24,BD,42,DB,99,66.
REQ-033 Scenario, mid-operation reset: pulse rst_n low during EXEC -> gnt, busy, res, res_valid immediately 0; no res_valid for that operation; next req=1000 is granted first to requester 3.
REQ-034 Scenario, illegal opcode: op=111 -> res=0, res_valid=1. With LOGIC_OP_ARBITER_ERR_EN, err=1 in the same cycle.
REQ-035 Scenario, late request: req1 raised during EXEC of requester 0 -> ignored until IDLE, then gnt=0010 with no extra delay.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// Four-requester round-robin arbiter that executes one bitwise logic operation per grant.
// Optional LOGIC_OP_ARBITER_ERR_EN adds an err output flagging opcodes 110/111.
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [11:0]        op,
  input  logic [4*WIDTH-1:0] a,
  input  logic [4*WIDTH-1:0] b,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   res,
  output logic               res_valid,
  output logic [1:0]         res_id
`ifdef LOGIC_OP_ARBITER_ERR_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       last_id;
  logic             win_vld;
  logic [1:0]       win_id;
  logic [1:0]       idx;

  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  logic [WIDTH-1:0] res_p1;
  logic             err_p1;
  logic             err_p2;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] opc,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (opc)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = ~(x | y);
      3'b011:  r = ~(x & y);
      3'b100:  r = x ^ y;
      3'b101:  r = ~(x ^ y);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic op_illegal(input logic [2:0] opc);
    return opc[2] & opc[1];
  endfunction

  // Round-robin search starts one past the last winner and wraps 3 -> 0.
  always_comb begin
    win_vld = 1'b0;
    win_id  = last_id;
    idx     = last_id;
    for (int k = 1; k <= 4; k++) begin
      idx = last_id + 2'(k);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = 4'b0000;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) state_nxt = GRANT;
      end
      GRANT: begin
        gnt       = 4'b0001 << last_id;
        busy      = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture the winner's opcode and operands on the IDLE->GRANT edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 2'd3;
      op_p0   <= '0;
      a_p0    <= '0;
      b_p0    <= '0;
    end else if (state == IDLE && win_vld) begin
      last_id <= win_id;
      op_p0   <= op[3*int'(win_id) +: 3];
      a_p0    <= a[WIDTH*int'(win_id) +: WIDTH];
      b_p0    <= b[WIDTH*int'(win_id) +: WIDTH];
    end
  end

  // Stage p1: evaluate the logic function on the GRANT->EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
      err_p1 <= 1'b0;
    end else if (state == GRANT) begin
      res_p1 <= logic_op(op_p0, a_p0, b_p0);
      err_p1 <= op_illegal(op_p0);
    end
  end

  // Stage p2: publish on EXEC->DONE so res/res_id stay put until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res    <= '0;
      res_id <= 2'd0;
      err_p2 <= 1'b0;
    end else if (state == EXEC) begin
      res    <= res_p1;
      res_id <= last_id;
      err_p2 <= err_p1;
    end
  end

`ifdef LOGIC_OP_ARBITER_ERR_EN
  assign err = (state == DONE) && err_p2;
`else
  logic unused_err;
  assign unused_err = err_p2;
`endif

endmodule
